glyph_ram_loader: RTL
=====================

# glyph_ram_loader

Write-side companion to the glyph bit generator. It accepts a byte stream of glyph-load commands from a host link (UART/SPI bridge): a 2-byte address followed by 8 row bytes. It assembles each glyph into a 64-bit word and issues a single-cycle write into the glyph RAM, which the bit generator reads during scan-out. The bit layout matches the reader exactly: row 0 in `data[63:56]`, and bit 7 of each row byte is the leftmost pixel.

## Interface
- `DATA_WIDTH`, default 64: glyph word width. Only 64 is supported (8 rows × 8 bits).
- `ADDR_WIDTH`, default 12: glyph RAM address width. Legal range is 1..16.
- `clk` input, 1 bit: the single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `bright` input, 1 bit: active-display flag, synchronous to `clk`. High means the reader is scanning.
- `resync` input, 1 bit: synchronous framing abort. Returns the block to address-high state.
- `in_valid` input, 1 bit: upstream byte valid.
- `in_byte` input, 8 bits: upstream byte.
- `in_ready` output, 1 bit: block can accept a byte this cycle.
- `we` output, 1 bit: glyph RAM write enable, one-cycle pulse.
- `waddr` output, `ADDR_WIDTH` bits: glyph RAM write address.
- `wdata` output, `DATA_WIDTH` bits: glyph RAM write data.
- `wr_count` output, 16 bits: number of completed writes. Wraps modulo 2^16.

## Operation
- A transfer occurs on a rising edge where `in_valid && in_ready`. No transfer occurs while `rst_n` is low.
- States:
  - S_AHI: accept a byte into `addr_hi` → S_ALO.
  - S_ALO: accept a byte into `addr_lo` → S_ROW, with row counter = 0.
  - S_ROW: each accepted byte shifts in (`sr <= {sr[55:0], in_byte}`) and the counter increments. The 8th byte (counter = 7) moves to S_WAIT if `GLYPH_LOAD_BLANK_ONLY_EN` is defined, else to S_WR.
  - S_WAIT: hold. Go to S_WR on an edge where `bright == 0`.
  - S_WR: `we = 1` for exactly this cycle, then → S_AHI. `wr_count` increments on the same edge that leaves S_WR.
- `in_ready` = 1 in S_AHI, S_ALO and S_ROW. It is 0 in S_WAIT and S_WR, and is decoded from the state register.
- `waddr` = `{addr_hi, addr_lo}[ADDR_WIDTH-1:0]`. Upper bits are silently ignored.
- `wdata` is the assembled shift register. `waddr` and `wdata` are registered and stable for the whole S_WR cycle. They hold their last values until the next glyph completes.
- `resync` has priority over any transfer on the same edge:
  - The state goes to S_AHI and the row counter clears.
  - A partial glyph is discarded. A glyph pending in S_WAIT is discarded and `wr_count` is not incremented.
  - If asserted while in S_WR, the write still occurs (`we` is already high) and `wr_count` increments.
- Back-to-back stalls, where `in_valid` is low mid-glyph, are legal with no timeout.
- Reset values:
  - State = S_AHI.
  - Row counter = 0.
  - `we` = 0, `waddr` = 0, `wdata` = 0, `wr_count` = 0.
  - `addr_hi` = `addr_lo` = 0.
  - `in_ready` reads 1, because the reset state is S_AHI.
- Reset asserted mid-glyph or in S_WAIT/S_WR drops `we` immediately and loses the glyph.

## Timing
- Let the last row byte be accepted on edge N.
- Without the macro: `we` is high in the cycle after N (through edge N+1), and `in_ready` is low in that same cycle. The next address-high byte can be accepted at edge N+2.
- With the macro: the block is in S_WAIT in the cycle after N. If `bright` = 0 at edge N+1, `we` is high in the cycle after edge N+1, giving a minimum 2-cycle latency. Otherwise `we` waits for the first edge with `bright` = 0.
- Minimum glyph period: 11 cycles without the macro, 12 with it.
- All outputs are registered or state-decoded. No combinational path exists from `in_valid` or `in_byte` to any output.

## Configuration
- `GLYPH_LOAD_BLANK_ONLY_EN` defined: the S_WAIT state is present, and writes happen only when `bright` = 0. This prevents tearing on a single-port or read-priority glyph RAM.
- Not defined: S_WAIT is not built, `bright` is unused, and writes issue immediately.

## Test plan
- Single glyph, no macro: send `0x0A, 0xBC, 0x18, 0x24, 0x42, 0x7E, 0x42, 0x42, 0x42, 0x00` with `in_valid` held high.
  - Expect one `we` pulse 1 cycle after the last byte, `waddr = 0xABC`, `wdata = 0x182442_7E42424200`, and `wr_count` = 1.
  - Expect `in_ready` low only during the S_WR cycle.
- Address truncation: header `0xFF, 0xFF` with `ADDR_WIDTH` = 12 → `waddr = 0xFFF`.
- Blank gating with the macro: hold `bright` = 1 for 50 cycles after the 10th byte.
  - Expect no `we`, `in_ready` = 0 throughout, then drop `bright`.
  - Expect `we` exactly 1 cycle after the first edge with `bright` = 0.
- Resync:
  - After 5 row bytes, pulse `resync`, then send a full glyph to address 0x001. Expect exactly one write, to 0x001, containing only the new rows.
  - Pulse `resync` in S_WAIT. Expect no write and `wr_count` unchanged.
- Async reset mid-glyph: drop `rst_n` after 4 row bytes. Expect `we`, `waddr`, `wdata` and `wr_count` to read 0 immediately. After release, a fresh 10-byte glyph writes correctly.
- Throttled input: randomize `in_valid` gaps of 0–5 cycles over 300 glyphs.
  - Every glyph is written once with the correct address and data.
  - `wr_count` reaches 300 (0x012C).

Source files
------------

// File: rtl/glyph_ram_loader.sv
// Glyph RAM loader: assembles {addr_hi, addr_lo, 8 rows} byte commands into 64-bit glyph writes.
// Optional GLYPH_LOAD_BLANK_ONLY_EN holds each write until the reader is in blanking (bright low).
module glyph_ram_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bright,
    input  logic                  resync,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [15:0]           wr_count
);

    typedef enum logic [2:0] {
        S_AHI,
        S_ALO,
        S_ROW,
`ifdef GLYPH_LOAD_BLANK_ONLY_EN
        S_WAIT,
`endif
        S_WR
    } state_t;

    state_t      state, state_d;
    logic [7:0]  addr_hi, addr_lo;
    logic [63:0] sr;
    logic [2:0]  row_cnt;
    logic        xfer;
    logic        last_row;
    logic        load;
    logic [15:0] addr_full;
    logic [63:0] glyph_d;
    logic        unused_ok;

    assign in_ready  = (state == S_AHI) || (state == S_ALO) || (state == S_ROW);
    assign we        = (state == S_WR);
    assign xfer      = in_valid && in_ready;
    assign last_row  = (state == S_ROW) && xfer && (row_cnt == 3'd7);
    assign addr_full = {addr_hi, addr_lo};

`ifdef GLYPH_LOAD_BLANK_ONLY_EN
    // Glyph is already complete in sr; latch it when the blank window opens.
    assign load      = (state == S_WAIT) && !bright && !resync;
    assign glyph_d   = sr;
    assign unused_ok = ^addr_full;
`else
    assign load      = last_row && !resync;
    assign glyph_d   = {sr[55:0], in_byte};
    assign unused_ok = ^{addr_full, bright};
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_AHI: if (xfer) state_d = S_ALO;
            S_ALO: if (xfer) state_d = S_ROW;
            S_ROW: begin
                if (last_row) begin
`ifdef GLYPH_LOAD_BLANK_ONLY_EN
                    state_d = S_WAIT;
`else
                    state_d = S_WR;
`endif
                end
            end
`ifdef GLYPH_LOAD_BLANK_ONLY_EN
            S_WAIT: if (!bright) state_d = S_WR;
`endif
            S_WR:    state_d = S_AHI;
            default: state_d = S_AHI;
        endcase
        if (resync) state_d = S_AHI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_AHI;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi <= 8'd0;
            addr_lo <= 8'd0;
            sr      <= 64'd0;
            row_cnt <= 3'd0;
        end else if (resync) begin
            row_cnt <= 3'd0;
        end else if (xfer) begin
            case (state)
                S_AHI: addr_hi <= in_byte;
                S_ALO: begin
                    addr_lo <= in_byte;
                    row_cnt <= 3'd0;
                end
                S_ROW: begin
                    sr      <= {sr[55:0], in_byte};
                    row_cnt <= row_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // waddr/wdata change only when a glyph is committed, so they hold through S_WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr <= '0;
            wdata <= '0;
        end else if (load) begin
            waddr <= addr_full[ADDR_WIDTH-1:0];
            wdata <= glyph_d[DATA_WIDTH-1:0];
        end
    end

    // A write in progress always completes, even with resync on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= 16'd0;
        end else if (state == S_WR) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule
